id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage feeding the 16-bit ALU: registers decoded operands and control from the decode stage.
- Resolves data hazards by forwarding from EX/MEM and MEM/WB into alu_a/alu_b.
- Detects load-use hazards, inserts bubbles and honours branch flush and downstream hold.
- Presents alu_a, alu_b, alu_ctrl and the EX-stage control bundle to the ALU and the EX/MEM register.

Parameters:
- DW, 16, datapath width.
- RAW, 3, register address width; register 0 reads as zero and is never a forwarding target.
- CW, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode presents a valid instruction.
- id_rs, id_rt, id_rd  in  RAW each  source and destination register numbers.
- id_rs_data, id_rt_data  in  DW each  register-file read data.
- id_imm  in  DW  sign-extended immediate.
- id_use_imm  in  1  alu_b takes the immediate instead of rt.
- id_alu_ctrl  in  4  ALU opcode, ALU encoding 0x0..0xC.
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control flags.
- exm_reg_write  in  1  EX/MEM writes a register.
- exm_rd  in  RAW  EX/MEM destination register.
- exm_result  in  DW  EX/MEM result.
- mwb_reg_write  in  1  MEM/WB writes a register.
- mwb_rd  in  RAW  MEM/WB destination register.
- mwb_result  in  DW  MEM/WB result.
- flush  in  1  branch/jump resolved taken; kill the instruction being captured.
- ex_hold  in  1  downstream stall; freeze this stage.
- id_stall  out  1  decode must hold its current instruction.
- ex_valid  out  1  stage holds a valid instruction.
- alu_a, alu_b  out  DW each  forwarded ALU operands.
- alu_ctrl  out  4  ALU opcode; 4'hF when ex_valid=0.
- ex_rd  out  RAW  destination register.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  flags gated by ex_valid.
- ex_store_data  out  DW  forwarded rt value for stores.
- bubble_count  out  CW  saturating count of load-use bubbles.

Behaviour:
- Reset (async, rst_n=0): all registers 0; ex_valid=0, alu_ctrl=4'hF, gated flags 0, bubble_count=0, id_stall=0.
- Captured state: valid, rs, rt, rd, rs_data, rt_data, imm, use_imm, alu_ctrl, reg_write, mem_read, mem_write.
- Per-edge priority:
  - flush: valid<=0.
  - else ex_hold: all state held.
  - else load-use hazard: valid<=0 (bubble), bubble_count+=1, saturating at all-ones.
  - else: capture id_* with valid<=id_valid.
- Load-use hazard (combinational) = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (id_rs==ex_rd | ((~id_use_imm | id_mem_write) & id_rt==ex_rd)).
- id_stall = ~flush & (ex_hold | hazard).
- Forwarding is combinational from the registered state; fwd(r, data):
  - if r==0: 0.
  - else if exm_reg_write & exm_rd==r: exm_result.
  - else if mwb_reg_write & mwb_rd==r: mwb_result.
  - else data.
- alu_a = fwd(rs, rs_data).
- ex_store_data = fwd(rt, rt_data).
- alu_b = use_imm ? imm : fwd(rt, rt_data).
- Forwarding continues to track the exm/mwb buses while held.
- Latency: one cycle from id_* capture to the outputs.
- ex_valid=0: alu_ctrl forced to 4'hF (ALU default, result 0); ex_reg_write, ex_mem_read, ex_mem_write forced 0. alu_a, alu_b and ex_rd don't care.
- Simultaneous flush and hazard: flush wins, no bubble counted, id_stall=0.
- Reset mid-operation clears the stage immediately regardless of hold or flush.

Test Plan:
- Reset, then load id_rs=1 (data 0x0003), id_rt=2 (data 0x0004), ctrl 0x0, no hazards -> next cycle ex_valid=1, alu_a=0x0003, alu_b=0x0004, alu_ctrl=0x0.
- Stage holds rs=3 (data 0x1111); exm_reg_write=1, exm_rd=3, exm_result=0xAAAA; mwb_reg_write=1, mwb_rd=3, mwb_result=0xBBBB -> alu_a=0xAAAA. Drop exm_reg_write -> alu_a=0xBBBB. Then rs=0 with both buses targeting rd=0 -> alu_a=0x0000.
- EX holds a load, ex_rd=5, mem_read=1; decode presents id_rs=5 -> id_stall=1 for one cycle; next cycle ex_valid=0, alu_ctrl=0xF, bubble_count=1. The following cycle captures the instruction with id_stall=0.
- Same load with id_use_imm=1, id_rt=5, id_mem_write=0 -> no stall. Repeat with id_mem_write=1 -> stall.
- ex_hold=1 for 3 cycles with changing id_* -> outputs unchanged and id_stall=1. Assert flush during the hold -> ex_valid=0 next cycle.
- Force 2^CW−1 bubbles, then one more -> bubble_count stays 0xFFFF. Assert rst_n=0 mid-stream -> all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/id_ex_if.sv
// id_ex_if: decode, forwarding and control inputs plus ALU-facing outputs of the ID/EX stage
interface id_ex_if #(
    parameter int DW  = 16,
    parameter int RAW = 3,
    parameter int CW  = 16
);
    logic           id_valid;
    logic [RAW-1:0] id_rs;
    logic [RAW-1:0] id_rt;
    logic [RAW-1:0] id_rd;
    logic [DW-1:0]  id_rs_data;
    logic [DW-1:0]  id_rt_data;
    logic [DW-1:0]  id_imm;
    logic           id_use_imm;
    logic [3:0]     id_alu_ctrl;
    logic           id_reg_write;
    logic           id_mem_read;
    logic           id_mem_write;
    logic           exm_reg_write;
    logic [RAW-1:0] exm_rd;
    logic [DW-1:0]  exm_result;
    logic           mwb_reg_write;
    logic [RAW-1:0] mwb_rd;
    logic [DW-1:0]  mwb_result;
    logic           flush;
    logic           ex_hold;
    logic           id_stall;
    logic           ex_valid;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [3:0]     alu_ctrl;
    logic [RAW-1:0] ex_rd;
    logic           ex_reg_write;
    logic           ex_mem_read;
    logic           ex_mem_write;
    logic [DW-1:0]  ex_store_data;
    logic [CW-1:0]  bubble_count;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_use_imm,
               id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
               exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
               flush, ex_hold,
        input  id_stall, ex_valid, alu_a, alu_b, alu_ctrl, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_store_data, bubble_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_use_imm,
               id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
               exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
               flush, ex_hold,
        output id_stall, ex_valid, alu_a, alu_b, alu_ctrl, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_store_data, bubble_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM and MEM/WB forwarding, load-use bubbles, flush and hold
module id_ex_stage #(
    parameter int DW  = 16,
    parameter int RAW = 3,
    parameter int CW  = 16
) (
    input logic    clk,
    input logic    rst_n,
    id_ex_if.slave bus
);
    logic           r_valid;
    logic [RAW-1:0] r_rs;
    logic [RAW-1:0] r_rt;
    logic [RAW-1:0] r_rd;
    logic [DW-1:0]  r_rs_data;
    logic [DW-1:0]  r_rt_data;
    logic [DW-1:0]  r_imm;
    logic           r_use_imm;
    logic [3:0]     r_alu_ctrl;
    logic           r_reg_write;
    logic           r_mem_read;
    logic           r_mem_write;
    logic [CW-1:0]  r_bubble;
    logic           w_hazard;
    logic [DW-1:0]  w_fwd_rs;
    logic [DW-1:0]  w_fwd_rt;

    // a load in EX whose destination is read by the instruction in decode must wait one cycle
    always_comb begin
        w_hazard = r_valid & r_mem_read & (r_rd != '0) & bus.id_valid &
                   ((bus.id_rs == r_rd) | ((~bus.id_use_imm | bus.id_mem_write) & (bus.id_rt == r_rd)));
    end

    // forward the youngest in-flight result; register 0 is hard-wired to zero
    always_comb begin
        w_fwd_rs = (r_rs == '0) ? '0 :
                   (bus.exm_reg_write && bus.exm_rd == r_rs) ? bus.exm_result :
                   (bus.mwb_reg_write && bus.mwb_rd == r_rs) ? bus.mwb_result : r_rs_data;
        w_fwd_rt = (r_rt == '0) ? '0 :
                   (bus.exm_reg_write && bus.exm_rd == r_rt) ? bus.exm_result :
                   (bus.mwb_reg_write && bus.mwb_rd == r_rt) ? bus.mwb_result : r_rt_data;
    end

    // flush beats hold, hold beats bubble insertion, otherwise capture the decoded instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_alu_ctrl  <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_bubble    <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (!bus.ex_hold) begin
            if (w_hazard) begin
                r_valid  <= 1'b0;
                r_bubble <= r_bubble + {{(CW-1){1'b0}}, ~&r_bubble};
            end else begin
                r_valid     <= bus.id_valid;
                r_rs        <= bus.id_rs;
                r_rt        <= bus.id_rt;
                r_rd        <= bus.id_rd;
                r_rs_data   <= bus.id_rs_data;
                r_rt_data   <= bus.id_rt_data;
                r_imm       <= bus.id_imm;
                r_use_imm   <= bus.id_use_imm;
                r_alu_ctrl  <= bus.id_alu_ctrl;
                r_reg_write <= bus.id_reg_write;
                r_mem_read  <= bus.id_mem_read;
                r_mem_write <= bus.id_mem_write;
            end
        end
    end

    assign bus.id_stall      = ~bus.flush & (bus.ex_hold | w_hazard);
    assign bus.ex_valid      = r_valid;
    assign bus.alu_a         = w_fwd_rs;
    assign bus.alu_b         = r_use_imm ? r_imm : w_fwd_rt;
    assign bus.alu_ctrl      = r_valid ? r_alu_ctrl : 4'hF;
    assign bus.ex_rd         = r_rd;
    assign bus.ex_reg_write  = r_valid & r_reg_write;
    assign bus.ex_mem_read   = r_valid & r_mem_read;
    assign bus.ex_mem_write  = r_valid & r_mem_write;
    assign bus.ex_store_data = w_fwd_rt;
    assign bus.bubble_count  = r_bubble;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table plus saturation and async-reset sequences for id_ex_stage
module tb_id_ex_stage;
    localparam int TB_CW = 10;

    typedef struct {
        logic             iv;
        logic [2:0]       rs, rt, rd;
        logic [15:0]      rsd, rtd, imm;
        logic             ui;
        logic [3:0]       op;
        logic             rw, mr, mw;
        logic             ew;
        logic [2:0]       erd;
        logic [15:0]      eres;
        logic             ww;
        logic [2:0]       wrd;
        logic [15:0]      wres;
        logic             fl, hd;
        logic             xs, xv;
        logic [15:0]      xa, xb;
        logic [3:0]       xop;
        logic [2:0]       xrd, xfl;
        logic [15:0]      xsd;
        logic [TB_CW-1:0] xbub;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    vec_t v[19];

    id_ex_if #(.DW(16), .RAW(3), .CW(TB_CW)) bus ();

    id_ex_stage #(.DW(16), .RAW(3), .CW(TB_CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.id_valid      = t.iv;
        bus.id_rs         = t.rs;
        bus.id_rt         = t.rt;
        bus.id_rd         = t.rd;
        bus.id_rs_data    = t.rsd;
        bus.id_rt_data    = t.rtd;
        bus.id_imm        = t.imm;
        bus.id_use_imm    = t.ui;
        bus.id_alu_ctrl   = t.op;
        bus.id_reg_write  = t.rw;
        bus.id_mem_read   = t.mr;
        bus.id_mem_write  = t.mw;
        bus.exm_reg_write = t.ew;
        bus.exm_rd        = t.erd;
        bus.exm_result    = t.eres;
        bus.mwb_reg_write = t.ww;
        bus.mwb_rd        = t.wrd;
        bus.mwb_result    = t.wres;
        bus.flush         = t.fl;
        bus.ex_hold       = t.hd;
    endtask

    task automatic step(input vec_t t);
        @(negedge clk);
        drive(t);
        @(posedge clk);
    endtask

    task automatic chk_idle(input int idx);
        chk(idx, "ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk(idx, "alu_ctrl", {28'd0, bus.alu_ctrl}, 32'hF);
        chk(idx, "flags", {29'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 32'd0);
    endtask

    initial begin
        vec_t z;
        n_tests = 0;
        n_fail  = 0;
        //      iv rs rt rd rsd      rtd      imm      ui op    rw mr mw  ew erd eres     ww wrd wres     fl hd  xs xv xa       xb       xop   xrd xfl     xsd      xbub
        v[0]  = '{1, 1, 2, 3, 'h0003, 'h0004, 0,       0, 'h0, 1, 0, 0,  0, 0, 0,        0, 0, 0,        0, 0,  0, 1, 'h0003, 'h0004, 'h0, 3, 3'b100, 'h0004, 0};
        v[1]  = '{1, 3, 4, 6, 'h1111, 'h2222, 0,       0, 'h2, 1, 0, 0,  1, 3, 'hAAAA,   1, 3, 'hBBBB,   0, 0,  0, 1, 'hAAAA, 'h2222, 'h2, 6, 3'b100, 'h2222, 0};
        v[2]  = '{1, 7, 7, 1, 'h9999, 'h9999, 0,       0, 'h5, 0, 1, 0,  0, 3, 'hAAAA,   1, 3, 'hBBBB,   0, 1,  1, 1, 'hBBBB, 'h2222, 'h2, 6, 3'b100, 'h2222, 0};
        v[3]  = '{1, 6, 6, 2, 'h8888, 'h8888, 0,       0, 'h6, 1, 0, 0,  1, 4, 'hCCCC,   0, 0, 0,        0, 1,  1, 1, 'h1111, 'hCCCC, 'h2, 6, 3'b100, 'hCCCC, 0};
        v[4]  = '{0, 5, 5, 5, 'h7777, 'h7777, 0,       0, 'h7, 1, 1, 1,  0, 0, 0,        0, 0, 0,        0, 1,  1, 1, 'h1111, 'h2222, 'h2, 6, 3'b100, 'h2222, 0};
        v[5]  = '{1, 0, 0, 1, 'h5555, 'h6666, 0,       0, 'h1, 1, 0, 0,  1, 0, 'hAAAA,   1, 0, 'hBBBB,   0, 0,  0, 1, 'h0000, 'h0000, 'h1, 1, 3'b100, 'h0000, 0};
        v[6]  = '{1, 1, 2, 2, 'h0010, 'h0020, 'hFFF0,  1, 'h3, 1, 0, 0,  1, 2, 'h7777,   0, 0, 0,        0, 0,  0, 1, 'h0010, 'hFFF0, 'h3, 2, 3'b100, 'h7777, 0};
        v[7]  = '{1, 1, 0, 5, 'h0100, 'h0000, 'h0004, 1, 'h0, 1, 1, 0,  0, 0, 0,        0, 0, 0,        0, 0,  0, 1, 'h0100, 'h0004, 'h0, 5, 3'b110, 'h0000, 0};
        v[8]  = '{1, 5, 1, 6, 'h0000, 'h0009, 0,       0, 'h1, 1, 0, 0,  0, 0, 0,        0, 0, 0,        0, 0,  1, 0, 'h0000, 'h0000, 'hF, 0, 3'b000, 'h0000, 1};
        v[9]  = '{1, 5, 1, 6, 'h0000, 'h0009, 0,       0, 'h1, 1, 0, 0,  1, 5, 'h1234,   0, 0, 0,        0, 0,  0, 1, 'h1234, 'h0009, 'h1, 6, 3'b100, 'h0009, 1};
        v[10] = '{1, 1, 0, 5, 'h0100, 'h0000, 'h0004, 1, 'h0, 1, 1, 0,  0, 0, 0,        0, 0, 0,        0, 0,  0, 1, 'h0100, 'h0004, 'h0, 5, 3'b110, 'h0000, 1};
        v[11] = '{1, 2, 5, 3, 'h0001, 'h0000, 'h0008, 1, 'h0, 1, 0, 0,  0, 0, 0,        0, 0, 0,        0, 0,  0, 1, 'h0001, 'h0008, 'h0, 3, 3'b100, 'h0000, 1};
        v[12] = '{1, 1, 0, 5, 'h0100, 'h0000, 'h0004, 1, 'h0, 1, 1, 0,  0, 0, 0,        0, 0, 0,        0, 0,  0, 1, 'h0100, 'h0004, 'h0, 5, 3'b110, 'h0000, 1};
        v[13] = '{1, 2, 5, 0, 'h0001, 'h0000, 'h0008, 1, 'h0, 0, 0, 1,  0, 0, 0,        0, 0, 0,        0, 0,  1, 0, 'h0000, 'h0000, 'hF, 0, 3'b000, 'h0000, 2};
        v[14] = '{1, 2, 5, 0, 'h0001, 'h0000, 'h0008, 1, 'h0, 0, 0, 1,  1, 5, 'h4321,   0, 0, 0,        0, 0,  0, 1, 'h0001, 'h0008, 'h0, 0, 3'b001, 'h4321, 2};
        v[15] = '{1, 1, 0, 5, 'h0100, 'h0000, 'h0004, 1, 'h0, 1, 1, 0,  0, 0, 0,        0, 0, 0,        0, 0,  0, 1, 'h0100, 'h0004, 'h0, 5, 3'b110, 'h0000, 2};
        v[16] = '{1, 5, 1, 6, 'h0000, 'h0009, 0,       0, 'h1, 1, 0, 0,  0, 0, 0,        0, 0, 0,        1, 0,  0, 0, 'h0000, 'h0000, 'hF, 0, 3'b000, 'h0000, 2};
        v[17] = '{1, 1, 2, 3, 'h0003, 'h0004, 0,       0, 'h0, 1, 0, 0,  0, 0, 0,        0, 0, 0,        0, 0,  0, 1, 'h0003, 'h0004, 'h0, 3, 3'b100, 'h0004, 2};
        v[18] = '{1, 4, 4, 4, 'h4444, 'h4444, 0,       0, 'h4, 1, 1, 1,  0, 0, 0,        0, 0, 0,        1, 1,  0, 0, 'h0000, 'h0000, 'hF, 0, 3'b000, 'h0000, 2};

        z = v[0];
        z.iv = 0; z.rs = 0; z.rt = 0; z.rd = 0; z.rsd = 0; z.rtd = 0; z.op = 0; z.rw = 0;
        rst_n = 1'b0;
        drive(z);
        repeat (2) @(posedge clk);
        #1;
        chk_idle(-1);
        chk(-1, "bubble_count", 32'(bus.bubble_count), 32'd0);
        chk(-1, "id_stall", {31'd0, bus.id_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(v[i]);
            #1;
            chk(i, "id_stall", {31'd0, bus.id_stall}, {31'd0, v[i].xs});
            @(posedge clk);
            #1;
            chk(i, "ex_valid", {31'd0, bus.ex_valid}, {31'd0, v[i].xv});
            chk(i, "alu_ctrl", {28'd0, bus.alu_ctrl}, {28'd0, v[i].xop});
            chk(i, "flags", {29'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, {29'd0, v[i].xfl});
            chk(i, "bubble_count", 32'(bus.bubble_count), 32'(v[i].xbub));
            if (v[i].xv) begin
                chk(i, "alu_a", {16'd0, bus.alu_a}, {16'd0, v[i].xa});
                chk(i, "alu_b", {16'd0, bus.alu_b}, {16'd0, v[i].xb});
                chk(i, "ex_rd", {29'd0, bus.ex_rd}, {29'd0, v[i].xrd});
                chk(i, "ex_store_data", {16'd0, bus.ex_store_data}, {16'd0, v[i].xsd});
            end
        end

        // alternate load / dependent instruction: one bubble per pair until the counter is full
        for (int i = 0; i < (2 ** TB_CW) - 1 - 2; i++) begin
            step(v[7]);
            step(v[8]);
        end
        #1;
        chk(100, "bubble_full", 32'(bus.bubble_count), 32'((2 ** TB_CW) - 1));
        chk_idle(100);
        step(v[7]);
        step(v[8]);
        #1;
        chk(101, "bubble_sat", 32'(bus.bubble_count), 32'((2 ** TB_CW) - 1));

        // asynchronous reset while a load is held and a flush is pending
        step(v[7]);
        #1;
        chk(102, "pre_reset_valid", {31'd0, bus.ex_valid}, 32'd1);
        @(negedge clk);
        bus.ex_hold = 1'b1;
        bus.flush   = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle(103);
        chk(103, "bubble_count", 32'(bus.bubble_count), 32'd0);
        chk(103, "id_stall", {31'd0, bus.id_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
